// File: rtl/friscv_uart_host_pkg.sv
// Shared constants and types for the UART host: register offsets, status
// bit positions and the host state encoding.
package friscv_uart_host_pkg;

  // UART register offsets relative to the peripheral base address
  localparam logic [3:0] UART_CSR = 4'h0;
  localparam logic [3:0] UART_DIV = 4'h4;
  localparam logic [3:0] UART_TX  = 4'h8;
  localparam logic [3:0] UART_RX  = 4'hC;

  // Status bit positions inside the CSR read data
  localparam int UART_TX_FULL  = 10;
  localparam int UART_RX_EMPTY = 11;

  typedef enum logic [2:0] {
    INIT_DIV,
    INIT_CSR,
    POLL,
    TX_WR,
    RX_RD,
    GAP
  } host_state_t;

  // Absolute register address from base and offset
  function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                           input logic [3:0]  offset);
    return base + {28'b0, offset};
  endfunction

endpackage

// File: rtl/friscv_scfifo.sv
// Single-clock FIFO with first-word fall-through read port. Pointers carry
// one extra wrap bit so full and empty can be told apart without a counter.
module friscv_scfifo #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  pull,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign data_out = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Advance the pointers on accepted pushes and pops; both resets empty the FIFO
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pull && !empty) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge aclk) begin
    if (push && !full) mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
  end

endmodule

// File: rtl/friscv_uart_host.sv
// Register-port initiator for the UART: configures divider and CSR after
// reset, then polls the CSR and moves bytes between the core-side streams
// and the UART FIFOs without ever issuing an access the UART would stall on.
module friscv_uart_host
  import friscv_uart_host_pkg::*;
#(
  parameter int         ADDRW         = 16,
  parameter int         XLEN          = 32,
  parameter int         BASE_ADDR     = 0,
  parameter int         CLK_DIVIDER   = 4,
  parameter logic [7:0] CSR_INIT      = 8'h01,
  parameter int         TX_FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              srst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [7:0]        tx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [7:0]        rx_data,
  output logic              mst_en,
  output logic              mst_wr,
  output logic [ADDRW-1:0]  mst_addr,
  output logic [XLEN-1:0]   mst_wdata,
  output logic [XLEN/8-1:0] mst_strb,
  input  logic [XLEN-1:0]   mst_rdata,
  input  logic              mst_ready,
  output logic              init_done
);

  localparam int STRB_W = XLEN / 8;

  localparam logic [ADDRW-1:0]  ADDR_CSR  = ADDRW'(reg_addr(32'(BASE_ADDR), UART_CSR));
  localparam logic [ADDRW-1:0]  ADDR_DIV  = ADDRW'(reg_addr(32'(BASE_ADDR), UART_DIV));
  localparam logic [ADDRW-1:0]  ADDR_TX   = ADDRW'(reg_addr(32'(BASE_ADDR), UART_TX));
  localparam logic [ADDRW-1:0]  ADDR_RX   = ADDRW'(reg_addr(32'(BASE_ADDR), UART_RX));
  localparam logic [XLEN-1:0]   DIV_DATA  = XLEN'(CLK_DIVIDER);
  localparam logic [XLEN-1:0]   CSR_DATA  = {{(XLEN-8){1'b0}}, CSR_INIT};
  localparam logic [STRB_W-1:0] STRB_HALF = STRB_W'(2'b11);
  localparam logic [STRB_W-1:0] STRB_BYTE = STRB_W'(1'b1);

  host_state_t state;
  logic        favor_rx;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pull;
  logic [7:0]  fifo_head;
  logic        access_done;
  logic        status_tx_full;
  logic        status_rx_empty;
  logic        tx_cand;
  logic        rx_cand;
  logic        rx_load;
  logic        unused_rdata;

  assign access_done     = mst_en & mst_ready;
  assign status_tx_full  = mst_rdata[UART_TX_FULL];
  assign status_rx_empty = mst_rdata[UART_RX_EMPTY];
  assign tx_cand         = ~status_tx_full & ~fifo_empty;
  assign rx_cand         = ~status_rx_empty & ~rx_valid;
  assign tx_ready        = ~fifo_full;
  assign fifo_push       = tx_valid & ~fifo_full;
  assign fifo_pull       = (state == TX_WR) & access_done;
  assign rx_load         = (state == RX_RD) & access_done;
  assign unused_rdata    = ^{mst_rdata[XLEN-1:12], mst_rdata[9:8]};

  friscv_scfifo #(
    .ADDR_WIDTH ($clog2(TX_FIFO_DEPTH)),
    .DATA_WIDTH (8)
  ) tx_buffer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .srst     (srst),
    .data_in  (tx_data),
    .push     (fifo_push),
    .full     (fifo_full),
    .data_out (fifo_head),
    .pull     (fifo_pull),
    .empty    (fifo_empty)
  );

  // Host sequencer: each access is raised on entry to its state and dropped
  // on the edge that samples mst_ready; the poll result picks the next move
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= INIT_DIV;
      favor_rx  <= 1'b1;
      init_done <= 1'b0;
      mst_en    <= 1'b0;
      mst_wr    <= 1'b0;
      mst_addr  <= '0;
      mst_wdata <= '0;
      mst_strb  <= '0;
    end else if (srst) begin
      state     <= INIT_DIV;
      favor_rx  <= 1'b1;
      init_done <= 1'b0;
      mst_en    <= 1'b0;
      mst_wr    <= 1'b0;
      mst_addr  <= '0;
      mst_wdata <= '0;
      mst_strb  <= '0;
    end else begin
      case (state)
        INIT_DIV: begin
          if (!mst_en) begin
            mst_en    <= 1'b1;
            mst_wr    <= 1'b1;
            mst_addr  <= ADDR_DIV;
            mst_wdata <= DIV_DATA;
            mst_strb  <= STRB_HALF;
          end else if (mst_ready) begin
            mst_en <= 1'b0;
            state  <= INIT_CSR;
          end
        end
        INIT_CSR: begin
          if (!mst_en) begin
            mst_en    <= 1'b1;
            mst_wr    <= 1'b1;
            mst_addr  <= ADDR_CSR;
            mst_wdata <= CSR_DATA;
            mst_strb  <= STRB_BYTE;
          end else if (mst_ready) begin
            mst_en    <= 1'b0;
            init_done <= 1'b1;
            state     <= GAP;
          end
        end
        POLL: begin
          if (!mst_en) begin
            mst_en    <= 1'b1;
            mst_wr    <= 1'b0;
            mst_addr  <= ADDR_CSR;
            mst_wdata <= '0;
            mst_strb  <= '0;
          end else if (mst_ready) begin
            mst_en <= 1'b0;
            if (tx_cand && (!rx_cand || !favor_rx)) begin
              state    <= TX_WR;
              favor_rx <= 1'b1;
            end else if (rx_cand) begin
              state    <= RX_RD;
              favor_rx <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
        end
        TX_WR: begin
          if (!mst_en) begin
            mst_en    <= 1'b1;
            mst_wr    <= 1'b1;
            mst_addr  <= ADDR_TX;
            mst_wdata <= {{(XLEN-8){1'b0}}, fifo_head};
            mst_strb  <= STRB_BYTE;
          end else if (mst_ready) begin
            mst_en <= 1'b0;
            state  <= GAP;
          end
        end
        RX_RD: begin
          if (!mst_en) begin
            mst_en    <= 1'b1;
            mst_wr    <= 1'b0;
            mst_addr  <= ADDR_RX;
            mst_wdata <= '0;
            mst_strb  <= '0;
          end else if (mst_ready) begin
            mst_en <= 1'b0;
            state  <= GAP;
          end
        end
        GAP: begin
          mst_en    <= 1'b1;
          mst_wr    <= 1'b0;
          mst_addr  <= ADDR_CSR;
          mst_wdata <= '0;
          mst_strb  <= '0;
          state     <= POLL;
        end
        default: begin
          mst_en <= 1'b0;
          state  <= INIT_DIV;
        end
      endcase
    end
  end

  // Received-byte holding register: loaded by a completed RX read, held
  // until the consumer takes it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (srst) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (rx_load) begin
      rx_valid <= 1'b1;
      rx_data  <= mst_rdata[7:0];
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_friscv_uart_host.sv
// Bench for the UART host: a responder plays the UART register port, a
// monitor scores every completed access and every consumed byte against a
// rule-level model of polling, round-robin arbitration and byte ordering.
module tb_friscv_uart_host;

  localparam int ADDRW = 16;
  localparam int XLEN  = 32;

  typedef enum int {K_POLL, K_TX, K_RX, K_OTHER, K_ANY} kind_t;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              srst = 1'b0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [7:0]        tx_data = 8'h00;
  logic              rx_valid;
  logic              rx_ready = 1'b0;
  logic [7:0]        rx_data;
  logic              mst_en;
  logic              mst_wr;
  logic [ADDRW-1:0]  mst_addr;
  logic [XLEN-1:0]   mst_wdata;
  logic [XLEN/8-1:0] mst_strb;
  logic [XLEN-1:0]   mst_rdata = '0;
  logic              mst_ready = 1'b0;
  logic              init_done;

  int checks = 0;
  int failures = 0;

  // UART side status as the responder reports it
  logic       st_tx_full = 1'b0;
  logic       st_rx_empty = 1'b1;
  logic       stall = 1'b0;
  logic       rx_random = 1'b1;
  logic [7:0] rx_fixed = 8'hA5;

  // Reference model state
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  kind_t      dut_grants[$];
  kind_t      next_kind = K_POLL;
  int         init_idx = 0;
  int         tx_count = 0;
  bit         favor_rx = 1'b1;
  bit         contested = 1'b0;
  int         tx_writes = 0;
  int         rx_reads = 0;
  int         polls = 0;
  bit         prev_done = 1'b0;
  bit         prev_rx_held = 1'b0;
  logic [7:0] prev_rx_data = 8'h00;

  always #5 aclk = ~aclk;

  friscv_uart_host dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .mst_en    (mst_en),
    .mst_wr    (mst_wr),
    .mst_addr  (mst_addr),
    .mst_wdata (mst_wdata),
    .mst_strb  (mst_strb),
    .mst_rdata (mst_rdata),
    .mst_ready (mst_ready),
    .init_done (init_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got no event, expected one within the cycle budget", name);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_mst_en"}, 32'(mst_en), 32'h0);
    checkOutput({tag, "_mst_wr"}, 32'(mst_wr), 32'h0);
    checkOutput({tag, "_mst_addr"}, 32'(mst_addr), 32'h0);
    checkOutput({tag, "_mst_wdata"}, mst_wdata, 32'h0);
    checkOutput({tag, "_mst_strb"}, 32'(mst_strb), 32'h0);
    checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    checkOutput({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    checkOutput({tag, "_init_done"}, 32'(init_done), 32'h0);
  endtask

  // Offer one byte and hold it until the host accepts it
  task automatic applyStimulus(input logic [7:0] b);
    int budget = 300;
    bit taken = 1'b0;
    @(posedge aclk);
    #1;
    tx_valid = 1'b1;
    tx_data  = b;
    while (!taken && budget > 0) begin
      @(negedge aclk);
      taken = tx_ready;
      budget--;
    end
    if (!taken) timeoutFail("tx_accept");
    @(posedge aclk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // Register-port responder: ready one to three cycles after the request,
  // pulsed for a single cycle, status built from st_* variables
  initial begin : responder
    bit seen = 1'b0;
    int cnt = 0;
    int lat = 1;
    logic [7:0] b;
    forever begin
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        mst_ready = 1'b0;
        seen = 1'b0;
      end else if (mst_ready) begin
        mst_ready = 1'b0;
      end else if (mst_en && !stall) begin
        if (!seen) begin
          seen = 1'b1;
          cnt  = 0;
          lat  = $urandom_range(1, 3);
        end else begin
          cnt++;
          if (cnt >= lat) begin
            seen = 1'b0;
            mst_ready = 1'b1;
            if (!mst_wr && mst_addr == 16'h0) begin
              mst_rdata = {20'h0, st_rx_empty, st_tx_full, 1'b1, 1'b0, 8'($urandom)};
            end else if (!mst_wr && mst_addr == 16'hC) begin
              b = rx_random ? 8'($urandom) : rx_fixed;
              mst_rdata = {24'h0, b};
              rx_exp.push_back(b);
            end else begin
              mst_rdata = $urandom;
            end
          end
        end
      end
    end
  end

  // Score one completed access against the model
  task automatic handleAccess();
    kind_t kind;
    bit tx_c;
    bit rx_c;
    logic [7:0] e;
    if (mst_wr && mst_addr == 16'h8) kind = K_TX;
    else if (!mst_wr && mst_addr == 16'hC) kind = K_RX;
    else if (!mst_wr && mst_addr == 16'h0) kind = K_POLL;
    else kind = K_OTHER;
    if (init_idx == 0) begin
      checkOutput("init_div_wr", 32'(mst_wr), 32'h1);
      checkOutput("init_div_addr", 32'(mst_addr), 32'h4);
      checkOutput("init_div_data", mst_wdata, 32'h4);
      checkOutput("init_div_strb", 32'(mst_strb), 32'h3);
      checkOutput("init_done_early", 32'(init_done), 32'h0);
      init_idx = 1;
      return;
    end
    if (init_idx == 1) begin
      checkOutput("init_csr_wr", 32'(mst_wr), 32'h1);
      checkOutput("init_csr_addr", 32'(mst_addr), 32'h0);
      checkOutput("init_csr_data", mst_wdata, 32'h1);
      checkOutput("init_csr_strb", 32'(mst_strb), 32'h1);
      init_idx = 2;
      return;
    end
    if (init_idx == 2) begin
      checkOutput("init_done_at_poll", 32'(init_done), 32'h1);
      init_idx = 3;
    end
    checkOutput("access_kind", 32'(int'(kind)), 32'(int'(next_kind)));
    if (contested) begin
      dut_grants.push_back(kind);
      contested = 1'b0;
    end
    case (kind)
      K_POLL: begin
        polls++;
        tx_c = !mst_rdata[10] && (tx_count > 0);
        rx_c = !mst_rdata[11] && !rx_valid;
        if (tx_c && rx_c) begin
          contested = 1'b1;
          next_kind = favor_rx ? K_RX : K_TX;
        end else if (tx_c) next_kind = K_TX;
        else if (rx_c) next_kind = K_RX;
        else next_kind = K_POLL;
        if (next_kind == K_RX) favor_rx = 1'b0;
        else if (next_kind == K_TX) favor_rx = 1'b1;
      end
      K_TX: begin
        tx_writes++;
        if (tx_exp.size() == 0) begin
          timeoutFail("tx_unexpected_write");
        end else begin
          e = tx_exp.pop_front();
          checkOutput("tx_wdata", mst_wdata, {24'h0, e});
          tx_count--;
        end
        checkOutput("tx_strb", 32'(mst_strb), 32'h1);
        next_kind = K_POLL;
      end
      K_RX: begin
        rx_reads++;
        next_kind = K_POLL;
      end
      default: next_kind = K_POLL;
    endcase
  endtask

  // Monitor: samples mid-cycle, away from the active edge
  initial begin : monitor
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_done = 1'b0;
        prev_rx_held = 1'b0;
      end else begin
        if (prev_done) checkOutput("en_low_after_ready", 32'(mst_en), 32'h0);
        prev_done = 1'b0;
        if (prev_rx_held) checkOutput("rx_data_stable", 32'(rx_data), 32'(prev_rx_data));
        if (rx_valid && rx_ready) begin
          if (rx_exp.size() == 0) timeoutFail("rx_unexpected_byte");
          else checkOutput("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
        end
        prev_rx_held = rx_valid && !rx_ready;
        prev_rx_data = rx_data;
        if (mst_en && mst_ready) begin
          prev_done = 1'b1;
          handleAccess();
        end
        if (tx_valid && tx_ready) begin
          tx_count++;
          tx_exp.push_back(tx_data);
        end
      end
    end
  end

  initial begin : stimulus
    int b;
    int p0;
    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkResetOutputs("reset");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("tx_ready_after_reset", 32'(tx_ready), 32'h1);
    checkOutput("en_before_first_edge", 32'(mst_en), 32'h0);
    @(negedge aclk);
    checkOutput("first_request", 32'(mst_en), 32'h1);

    b = 0;
    while (polls < 1 && b < 100) begin @(negedge aclk); b++; end
    if (polls < 1) timeoutFail("init_sequence");

    // Single byte through an idle UART
    applyStimulus(8'h55);
    b = 0;
    while (tx_writes < 1 && b < 100) begin @(negedge aclk); b++; end
    if (tx_writes < 1) timeoutFail("tx_single");
    checkOutput("tx_ready_high", 32'(tx_ready), 32'h1);
    waitCycles(30);
    checkOutput("tx_single_count", 32'(tx_writes), 32'h1);

    // TX FIFO full: only polling until it clears
    st_tx_full = 1'b1;
    p0 = polls;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    waitCycles(40);
    checkOutput("no_tx_while_full", 32'(tx_writes), 32'h1);
    checkOutput("polling_continues", 32'(polls > p0 + 2), 32'h1);
    st_tx_full = 1'b0;
    b = 0;
    while (tx_writes < 3 && b < 100) begin @(negedge aclk); b++; end
    if (tx_writes < 3) timeoutFail("tx_after_full");

    // RX byte held while the consumer stalls
    rx_random = 1'b0;
    rx_ready  = 1'b0;
    st_rx_empty = 1'b0;
    b = 0;
    while (!rx_valid && b < 100) begin @(negedge aclk); b++; end
    if (!rx_valid) timeoutFail("rx_first");
    waitCycles(40);
    checkOutput("rx_single_read", 32'(rx_reads), 32'h1);
    checkOutput("rx_valid_held", 32'(rx_valid), 32'h1);
    checkOutput("rx_data_a5", 32'(rx_data), 32'hA5);
    st_rx_empty = 1'b1;
    @(posedge aclk); #1 rx_ready = 1'b1;
    @(posedge aclk); #1 rx_ready = 1'b0;
    waitCycles(5);
    checkOutput("rx_popped", 32'(rx_valid), 32'h0);
    rx_random = 1'b1;

    // One uncontested TX grant so arbitration favours RX next
    applyStimulus(8'h33);
    b = 0;
    while (tx_writes < 4 && b < 100) begin @(negedge aclk); b++; end
    if (tx_writes < 4) timeoutFail("tx_prearb");

    // Both directions pending: grants must alternate starting with RX
    st_tx_full = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(8'($urandom));
    waitCycles(10);
    dut_grants.delete();
    rx_ready = 1'b1;
    @(posedge aclk);
    #1;
    st_tx_full  = 1'b0;
    st_rx_empty = 1'b0;
    b = 0;
    while (dut_grants.size() < 4 && b < 300) begin @(negedge aclk); b++; end
    if (dut_grants.size() < 4) timeoutFail("rr_grants");
    else begin
      checkOutput("rr_grant_0", 32'(int'(dut_grants[0])), 32'(int'(K_RX)));
      checkOutput("rr_grant_1", 32'(int'(dut_grants[1])), 32'(int'(K_TX)));
      checkOutput("rr_grant_2", 32'(int'(dut_grants[2])), 32'(int'(K_RX)));
      checkOutput("rr_grant_3", 32'(int'(dut_grants[3])), 32'(int'(K_TX)));
    end
    st_rx_empty = 1'b1;
    waitCycles(100);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge aclk);
      #1;
      tx_valid    = ($urandom_range(0, 2) == 0);
      tx_data     = 8'($urandom);
      rx_ready    = ($urandom_range(0, 1) == 1);
      st_tx_full  = ($urandom_range(0, 3) == 0);
      st_rx_empty = ($urandom_range(0, 1) == 1);
    end
    @(posedge aclk);
    #1;
    tx_valid    = 1'b0;
    rx_ready    = 1'b1;
    st_tx_full  = 1'b0;
    st_rx_empty = 1'b1;
    waitCycles(200);
    checkOutput("tx_drained", 32'(tx_exp.size()), 32'h0);
    checkOutput("rx_drained", 32'(rx_exp.size()), 32'h0);

    // Reset in the middle of a stalled access
    stall = 1'b1;
    b = 0;
    while (!mst_en && b < 50) begin @(negedge aclk); b++; end
    if (!mst_en) timeoutFail("stall_wait");
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    checkResetOutputs("midreset");
    checkOutput("midreset_tx_ready", 32'(tx_ready), 32'h1);
    tx_exp.delete();
    rx_exp.delete();
    tx_count  = 0;
    favor_rx  = 1'b1;
    contested = 1'b0;
    init_idx  = 0;
    next_kind = K_POLL;
    stall     = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    b = 0;
    while (init_idx < 3 && b < 100) begin @(negedge aclk); b++; end
    if (init_idx < 3) timeoutFail("reinit");
    checkOutput("reinit_done", 32'(init_done), 32'h1);
    waitCycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
